// File: rtl/sys_cmd_ctrl.sv
// ============================================================================
// sys_cmd_ctrl
// ----------------------------------------------------------------------------
// Command sequencer between the UART RX parallel output and the register
// file / ALU datapath, in the REF_CLK domain. Framed commands:
//   AA addr data      register write
//   BB addr           register read; read byte is returned on TX
//   CC opa opb fun    write operands to OPA_ADDR/OPB_ADDR, then run the ALU
//   DD fun            run the ALU on the operands already in the register file
// ALU results go back low byte first, then high byte. TX bytes are only issued
// in cycles where FIFO_FULL is low; otherwise the controller holds its TX state.
//
// Optional build macro: CMD_ERR_RESP_EN
//   defined   -> an unknown command byte in IDLE returns one byte 0xEE on TX
//                (extra state TX_ERR)
//   undefined -> an unknown command byte is silently discarded
//
// Handshake: RX_D_VLD, RF_RD_DATA_VLD and ALU_OUT_VLD are single-cycle valid
// pulses with no ready; they are consumed only in the states that expect them
// and dropped everywhere else. TX_D_VLD is a single-cycle write strobe that is
// raised only after a cycle in which FIFO_FULL was sampled low.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   RX_P_DATA / RX_D_VLD      received byte and its valid pulse
//   RF_RD_DATA / _VLD         register file read data and valid pulse
//   ALU_OUT / ALU_OUT_VLD     ALU result (2*DATA_WIDTH) and valid pulse
//   FIFO_FULL                 TX FIFO full
//   RF_WR_EN/RF_RD_EN         register file strobes
//   RF_ADDR/RF_WR_DATA        register file address and write data
//   ALU_EN/ALU_FUN            ALU start strobe and function code
//   CLK_GATE_EN               ALU clock-gate enable
//   TX_P_DATA/TX_D_VLD        byte to TX FIFO and its write strobe
// All outputs are registered and reset to 0.
// ============================================================================
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int OPA_ADDR   = 0,
    parameter int OPB_ADDR   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NP = DATA_WIDTH'(8'hDD);
`ifdef CMD_ERR_RESP_EN
    localparam logic [DATA_WIDTH-1:0] ERR_BYTE   = DATA_WIDTH'(8'hEE);
`endif

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        FUN,
        ALU_WAIT,
        TX_LO,
        TX_HI,
        TX_RD
`ifdef CMD_ERR_RESP_EN
        , TX_ERR
`endif
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;   // address byte of a write frame
    logic [2*DATA_WIDTH-1:0] res_q;    // ALU result, or read data in the low byte

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            addr_q      <= '0;
            res_q       <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_DATA  <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless re-raised below.
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;

            // CLK_GATE_EN is set on every transition into FUN and cleared on
            // the transition out of ALU_WAIT, so it tracks "state is FUN or
            // ALU_WAIT" with no extra cycle of lag and is already high when
            // the function byte can issue ALU_EN.
            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == CMD_WR) begin
                            state <= WR_ADDR;
                        end else if (RX_P_DATA == CMD_RD) begin
                            state <= RD_ADDR;
                        end else if (RX_P_DATA == CMD_ALU_OP) begin
                            state <= OPA;
                        end else if (RX_P_DATA == CMD_ALU_NP) begin
                            state       <= FUN;
                            CLK_GATE_EN <= 1'b1;
                        end else begin
`ifdef CMD_ERR_RESP_EN
                            state <= TX_ERR;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end

                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state  <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= addr_q;
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RD_EN <= 1'b1;
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state    <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (RF_RD_DATA_VLD) begin
                        res_q <= {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                        state <= TX_RD;
                    end
                end

                OPA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= ADDR_WIDTH'(OPA_ADDR);
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= OPB;
                    end
                end

                OPB: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN    <= 1'b1;
                        RF_ADDR     <= ADDR_WIDTH'(OPB_ADDR);
                        RF_WR_DATA  <= RX_P_DATA;
                        state       <= FUN;
                        CLK_GATE_EN <= 1'b1;
                    end
                end

                FUN: begin
                    if (RX_D_VLD) begin
                        ALU_EN  <= 1'b1;
                        ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                        state   <= ALU_WAIT;
                    end
                end

                ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        res_q       <= ALU_OUT;
                        CLK_GATE_EN <= 1'b0;
                        state       <= TX_LO;
                    end
                end

                TX_LO: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= res_q[DATA_WIDTH-1:0];
                        state     <= TX_HI;
                    end
                end

                TX_HI: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        state     <= IDLE;
                    end
                end

                TX_RD: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= res_q[DATA_WIDTH-1:0];
                        state     <= IDLE;
                    end
                end

`ifdef CMD_ERR_RESP_EN
                TX_ERR: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= ERR_BYTE;
                        state     <= IDLE;
                    end
                end
`endif

                default: begin
                    state       <= IDLE;
                    CLK_GATE_EN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// ============================================================================
// tb_sys_cmd_ctrl
// ----------------------------------------------------------------------------
// Bench for sys_cmd_ctrl. Driver tasks send whole command frames and emulate
// the register file and ALU. Expected register writes, reads, ALU starts and TX
// bytes are pushed into queues at frame level; a single compare process checks
// every cycle that each strobe appears exactly when the frame rules say it
// must, pops the queues, and checks the ALU clock-gate window. The TX rule is:
// once a response is armed, the head byte goes out on the first clock edge
// that samples FIFO_FULL low, and never otherwise.
// Honours CMD_ERR_RESP_EN the same way as the design.
// ============================================================================
module tb_sys_cmd_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_p_data;
    logic        rx_d_vld;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_data_vld;
    logic [15:0] alu_out;
    logic        alu_out_vld;
    logic        fifo_full;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        clk_gate_en;
    logic [7:0]  tx_p_data;
    logic        tx_d_vld;

    sys_cmd_ctrl dut (
        .CLK            (clk),
        .RST            (rst),
        .RX_P_DATA      (rx_p_data),
        .RX_D_VLD       (rx_d_vld),
        .RF_RD_DATA     (rf_rd_data),
        .RF_RD_DATA_VLD (rf_rd_data_vld),
        .ALU_OUT        (alu_out),
        .ALU_OUT_VLD    (alu_out_vld),
        .FIFO_FULL      (fifo_full),
        .RF_WR_EN       (rf_wr_en),
        .RF_RD_EN       (rf_rd_en),
        .RF_ADDR        (rf_addr),
        .RF_WR_DATA     (rf_wr_data),
        .ALU_EN         (alu_en),
        .ALU_FUN        (alu_fun),
        .CLK_GATE_EN    (clk_gate_en),
        .TX_P_DATA      (tx_p_data),
        .TX_D_VLD       (tx_d_vld)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model state ----------------
    logic [11:0] wr_q[$];    // {addr, data}
    logic [3:0]  rd_q[$];
    logic [3:0]  fun_q[$];
    logic [7:0]  exp_q[$];   // TX bytes in order
    logic [7:0]  regs[16];   // bench register file

    logic exp_wr, exp_rd, exp_alu, gate_exp, chk_reset;
    logic tx_armed, bp_en, end_req, end_done;
    logic full_edge, due_edge;
    int   n_timeout, seen_timeout;
    int   tests, fails;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        full_edge <= fifo_full;
        due_edge  <= tx_armed && (exp_q.size() != 0);
    end

    always @(negedge clk) begin
        logic [11:0] w;
        logic [3:0]  a;
        logic        exp_tx;
        #1;
        if (chk_reset)
            check("reset_outputs",
                  {3'b0, rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_d_vld,
                   rf_addr, rf_wr_data, alu_fun, tx_p_data}, 32'h0);

        check("rf_wr_en", {31'b0, rf_wr_en}, {31'b0, exp_wr});
        if (rf_wr_en && exp_wr) begin
            if (wr_q.size() == 0) check("wr_q_empty", 32'd1, 32'd0);
            else begin
                w = wr_q.pop_front();
                check("rf_write", {20'b0, rf_addr, rf_wr_data}, {20'b0, w});
            end
        end

        check("rf_rd_en", {31'b0, rf_rd_en}, {31'b0, exp_rd});
        if (rf_rd_en && exp_rd) begin
            if (rd_q.size() == 0) check("rd_q_empty", 32'd1, 32'd0);
            else begin
                a = rd_q.pop_front();
                check("rf_rd_addr", {28'b0, rf_addr}, {28'b0, a});
            end
        end

        check("alu_en", {31'b0, alu_en}, {31'b0, exp_alu});
        if (alu_en && exp_alu) begin
            if (fun_q.size() == 0) check("fun_q_empty", 32'd1, 32'd0);
            else begin
                a = fun_q.pop_front();
                check("alu_fun", {28'b0, alu_fun}, {28'b0, a});
            end
        end

        check("clk_gate_en", {31'b0, clk_gate_en}, {31'b0, gate_exp});

        exp_tx = due_edge && !full_edge;
        check("tx_d_vld", {31'b0, tx_d_vld}, {31'b0, exp_tx});
        if (tx_d_vld && exp_tx && exp_q.size() != 0)
            check("tx_p_data", {24'b0, tx_p_data}, {24'b0, exp_q.pop_front()});

        if (n_timeout != seen_timeout) begin
            check("tx_drain_timeout", n_timeout, seen_timeout);
            seen_timeout = n_timeout;
        end

        if (end_req && !end_done) begin
            check("wr_q_left", wr_q.size(), 0);
            check("rd_q_left", rd_q.size(), 0);
            check("fun_q_left", fun_q.size(), 0);
            check("tx_q_left", exp_q.size(), 0);
            end_done = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        exp_wr    = 1'b0;
        exp_rd    = 1'b0;
        exp_alu   = 1'b0;
        chk_reset = 1'b0;
        if (bp_en) fifo_full = ($urandom_range(0, 2) == 0);
    endtask

    // kind bits: 0 write strobe, 1 read strobe, 2 ALU strobe, 3 gate opens
    task automatic send_byte(input logic [7:0] b, input logic [3:0] kind);
        rx_p_data = b;
        rx_d_vld  = 1'b1;
        tick();
        rx_d_vld  = 1'b0;
        exp_wr    = kind[0];
        exp_rd    = kind[1];
        exp_alu   = kind[2];
        if (kind[3]) gate_exp = 1'b1;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 300) begin
            tick();
            cnt++;
        end
        if (exp_q.size() != 0) begin
            n_timeout++;
            exp_q.delete();
        end
        tx_armed = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        wr_q.push_back({addr[3:0], data});
        regs[addr[3:0]] = data;
        send_byte(8'hAA, 4'h0);
        send_byte(addr, 4'h0);
        send_byte(data, 4'h1);
    endtask

    task automatic do_read(input logic [7:0] addr, input int dly);
        logic [7:0] d;
        d = regs[addr[3:0]];
        rd_q.push_back(addr[3:0]);
        send_byte(8'hBB, 4'h0);
        send_byte(addr, 4'h2);
        // junk traffic while the read is outstanding must be dropped
        send_byte(8'($urandom_range(0, 255)), 4'h0);
        alu_out_vld = 1'b1;
        tick();
        alu_out_vld = 1'b0;
        repeat (dly) tick();
        rf_rd_data     = d;
        rf_rd_data_vld = 1'b1;
        exp_q.push_back(d);
        tick();
        rf_rd_data_vld = 1'b0;
        tx_armed       = 1'b1;
        drain();
    endtask

    task automatic alu_respond(input logic [15:0] res, input int dly);
        send_byte(8'($urandom_range(0, 255)), 4'h0);
        rf_rd_data_vld = 1'b1;
        tick();
        rf_rd_data_vld = 1'b0;
        repeat (dly) tick();
        alu_out     = res;
        alu_out_vld = 1'b1;
        exp_q.push_back(res[7:0]);
        exp_q.push_back(res[15:8]);
        tick();
        alu_out_vld = 1'b0;
        gate_exp    = 1'b0;
        tx_armed    = 1'b1;
    endtask

    task automatic do_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        wr_q.push_back({4'h0, a});
        wr_q.push_back({4'h1, b});
        fun_q.push_back(f[3:0]);
        regs[0] = a;
        regs[1] = b;
        send_byte(8'hCC, 4'h0);
        send_byte(a, 4'h1);
        send_byte(b, 4'h9);
        send_byte(f, 4'h4);
    endtask

    task automatic do_alu_np(input logic [7:0] f);
        fun_q.push_back(f[3:0]);
        send_byte(8'hDD, 4'h8);
        send_byte(f, 4'h4);
    endtask

    task automatic do_unknown(input logic [7:0] b);
`ifdef CMD_ERR_RESP_EN
        exp_q.push_back(8'hEE);
        send_byte(b, 4'h0);
        tx_armed = 1'b1;
        drain();
`else
        send_byte(b, 4'h0);
        repeat (3) tick();
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        rst = 1'b1; rx_p_data = 8'h0; rx_d_vld = 1'b0;
        rf_rd_data = 8'h0; rf_rd_data_vld = 1'b0;
        alu_out = 16'h0; alu_out_vld = 1'b0; fifo_full = 1'b0;
        exp_wr = 1'b0; exp_rd = 1'b0; exp_alu = 1'b0; gate_exp = 1'b0;
        chk_reset = 1'b0; tx_armed = 1'b0; bp_en = 1'b0;
        end_req = 1'b0; end_done = 1'b0;
        n_timeout = 0; seen_timeout = 0; tests = 0; fails = 0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;

        tick(); tick();
        chk_reset = 1'b1;
        rst       = 1'b0;
        tick();

        // 1: register write AA 04 FB
        do_write(8'h04, 8'hFB);
        tick();
        // 2: register read of address 4 returns FB on TX
        do_read(8'h04, 1);
        // 3: CC 08 05 00, ALU returns 000D -> TX 0D, 00
        do_alu_op(8'h08, 8'h05, 8'h00);
        alu_respond(16'h000D, 1);
        drain();
        // 4: DD 01, ALU returns 0003, FIFO full for 10 cycles in TX_LO
        do_alu_np(8'h01);
        tick();
        alu_out     = 16'h0003;
        alu_out_vld = 1'b1;
        fifo_full   = 1'b1;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h00);
        tick();
        alu_out_vld = 1'b0;
        gate_exp    = 1'b0;
        tx_armed    = 1'b1;
        repeat (10) tick();
        fifo_full = 1'b0;
        drain();
        // 5: reset while waiting on the ALU, then a normal write
        do_alu_np(8'h02);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        chk_reset = 1'b1;
        gate_exp  = 1'b0;
        tx_armed  = 1'b0;
        exp_q.delete();
        tick();
        do_write(8'h05, 8'hC5);
        tick();
        // 6: unknown command, then a read of address 5
        do_unknown(8'h55);
        do_read(8'h05, 2);

        // randomized frames with random backpressure
        bp_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                1: do_read(8'($urandom_range(0, 255)), $urandom_range(0, 3));
                2: begin
                    do_alu_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              8'($urandom_range(0, 255)));
                    alu_respond(16'($urandom_range(0, 65535)), $urandom_range(0, 4));
                    drain();
                end
                3: begin
                    do_alu_np(8'($urandom_range(0, 255)));
                    alu_respond(16'($urandom_range(0, 65535)), $urandom_range(0, 4));
                    drain();
                end
                default: begin
                    b = 8'($urandom_range(0, 255));
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD)
                        b = 8'($urandom_range(0, 255));
                    do_unknown(b);
                end
            endcase
            // idle gap with stray valid pulses that must be ignored
            repeat ($urandom_range(0, 2)) begin
                alu_out_vld    = 1'($urandom_range(0, 1));
                rf_rd_data_vld = 1'($urandom_range(0, 1));
                tick();
                alu_out_vld    = 1'b0;
                rf_rd_data_vld = 1'b0;
            end
        end
        bp_en     = 1'b0;
        fifo_full = 1'b0;

        end_req = 1'b1;
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
